// File: rtl/axis_write_data.sv
// axis_write_data: packs a narrow word stream into wide AXI W beats through a small FIFO; define AXIS_WRITE_DATA_ZERO_PAD_EN to zero unused lanes of a partial final beat
module axis_write_data #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LENGTH   = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      done,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  output logic                      axi_wlast,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      valid,
  output logic                      ready
);
  localparam int DEPTH = 1 << BUF_AWIDTH;
  localparam int KW = WIDTH_RATIO > 1 ? $clog2(WIDTH_RATIO) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_nx;
  logic [CONFIG_DWIDTH-1:0] remaining, total, out_idx, burst_idx;
  logic [AXI_DATA_WIDTH-1:0] pack;
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [BUF_AWIDTH:0] count;
  logic [BUF_AWIDTH+1:0] occ;
  logic [KW-1:0] lane;
  logic push, accept, pop, last_beat;
  assign accept = valid && ready;
  assign pop = axi_wvalid && axi_wready;
  assign last_beat = out_idx == total - 1'b1;
  assign axi_wvalid = count != '0;
  assign axi_wdata = mem[rd_ptr];
  assign axi_wlast = axi_wvalid && (burst_idx == CONFIG_DWIDTH'(BURST_LENGTH - 1) || last_beat);
  // a completed beat waiting one cycle to be pushed already claims a FIFO slot
  assign occ = {1'b0, count} + {{(BUF_AWIDTH+1){1'b0}}, push};
  assign ready = state == ACTIVE && remaining != '0 && occ < (BUF_AWIDTH+2)'(DEPTH);
  assign done = state == DONE;
  // next-state: zero-length transfers skip straight to DONE; DONE lasts one cycle
  always_comb begin
    state_nx = state;
    if (state == IDLE && cfg_valid) state_nx = cfg_length == '0 ? DONE : ACTIVE;
    if (state == ACTIVE && pop && last_beat) state_nx = DONE;
    if (state == DONE) state_nx = IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // FIFO storage needs no reset; pointers and count carry validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pack;
  end
  // counters, packer and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      total <= '0;
      out_idx <= '0;
      burst_idx <= '0;
      lane <= '0;
      push <= 1'b0;
      pack <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (state == IDLE && cfg_valid) begin
        remaining <= cfg_length;
        total <= cfg_length / CONFIG_DWIDTH'(WIDTH_RATIO) + CONFIG_DWIDTH'(cfg_length % CONFIG_DWIDTH'(WIDTH_RATIO) != '0);
        out_idx <= '0;
        burst_idx <= '0;
        lane <= '0;
      end
      if (accept) begin
        remaining <= remaining - 1'b1;
        lane <= lane == KW'(WIDTH_RATIO - 1) ? '0 : lane + 1'b1;
`ifdef AXIS_WRITE_DATA_ZERO_PAD_EN
        if (lane == '0) pack <= AXI_DATA_WIDTH'(data);
        else pack[lane*DATA_WIDTH +: DATA_WIDTH] <= data;
`else
        pack[lane*DATA_WIDTH +: DATA_WIDTH] <= data;
`endif
      end
      push <= accept && (lane == KW'(WIDTH_RATIO - 1) || remaining == CONFIG_DWIDTH'(1));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        out_idx <= out_idx + 1'b1;
        burst_idx <= burst_idx == CONFIG_DWIDTH'(BURST_LENGTH - 1) ? '0 : burst_idx + 1'b1;
      end
      count <= count + {{BUF_AWIDTH{1'b0}}, push} - {{BUF_AWIDTH{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_axis_write_data.sv
// tb_axis_write_data: randomized self-checking bench for axis_write_data against a beat-level reference model
module tb_axis_write_data;
  localparam int BA = 4, CW = 32, WR = 8, DW = 32, AW = 256, BL = 256;
  logic clk = 0, rst, done, cfg_valid, axi_wvalid, axi_wready, axi_wlast, valid, ready;
  logic [CW-1:0] cfg_length;
  logic [AW-1:0] axi_wdata;
  logic [DW-1:0] data;
  int checks = 0, failures = 0;
  logic [AW-1:0] cap_data[$], exp_data[$];
  logic cap_last[$], exp_last[$];
  logic [DW-1:0] words[$];
  logic [DW-1:0] model_pack [WR];
  int done_cnt, stab_err, cyc = 0, acc_cnt, last_pop_cyc, done_cyc, hold_acc;
  logic prev_stall = 0, prev_last, hold_ready, hold_wvalid;
  logic [AW-1:0] prev_data;
  bit tmo;

  always #5 clk = ~clk;

  axis_write_data #(.BUF_AWIDTH(BA), .CONFIG_DWIDTH(CW), .WIDTH_RATIO(WR), .AXI_DATA_WIDTH(AW),
    .DATA_WIDTH(DW), .BURST_LENGTH(BL)) dut (
    .clk(clk), .rst(rst), .done(done), .cfg_length(cfg_length), .cfg_valid(cfg_valid),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .data(data), .valid(valid), .ready(ready));

  // observe handshakes and stall stability on the falling edge, when all inputs are settled
  always @(negedge clk) begin
    cyc++;
    if (rst) prev_stall = 0;
    else begin
      if (axi_wvalid && axi_wready) begin
        cap_data.push_back(axi_wdata);
        cap_last.push_back(axi_wlast);
        last_pop_cyc = cyc;
      end
      if (valid && ready) acc_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_stall && (!axi_wvalid || axi_wdata !== prev_data || axi_wlast !== prev_last)) stab_err++;
      prev_stall = axi_wvalid && !axi_wready;
      prev_data = axi_wdata;
      prev_last = axi_wlast;
    end
  end

  task automatic clear_cap();
    cap_data.delete(); cap_last.delete();
    done_cnt = 0; stab_err = 0; acc_cnt = 0; last_pop_cyc = -10; done_cyc = -100; tmo = 0;
  endtask

  // expected beats: words laid little-endian WR per beat; short final beat keeps or zeroes stale lanes
  task automatic build_model(input int len);
    int nb;
    exp_data.delete(); exp_last.delete();
    nb = (len + WR - 1) / WR;
    for (int b = 0; b < nb; b++) begin
      logic [AW-1:0] beat;
      for (int k = 0; k < WR; k++) begin
        if (b * WR + k < len) model_pack[k] = words[b * WR + k];
`ifdef AXIS_WRITE_DATA_ZERO_PAD_EN
        else model_pack[k] = '0;
`endif
        beat[k*DW +: DW] = model_pack[k];
      end
      exp_data.push_back(beat);
      exp_last.push_back((b % BL == BL - 1) || b == nb - 1);
    end
  endtask

  task automatic seq_words(input int len);
    words.delete();
    for (int i = 1; i <= len; i++) words.push_back(DW'(i));
  endtask

  task automatic rand_words(input int len);
    words.delete();
    for (int i = 0; i < len; i++) words.push_back($urandom);
  endtask

  // gap<0: random source gaps; wmode 0 ready, 1 toggling, 2 random; wready held 0 for the first hold cycles
  task automatic run_xfer(input int len, input int gap, input int wmode, input int hold);
    clear_cap();
    build_model(len);
    @(posedge clk); #1; cfg_length = CW'(len); cfg_valid = 1;
    @(posedge clk); #1; cfg_valid = 0;
    fork
      begin
        int idx = 0, wait_c = 0, t = 0;
        while (idx < len && t < 20000) begin
          valid = (wait_c == 0) && (gap >= 0 || $urandom_range(0, 1) == 1);
          data = words[idx];
          @(negedge clk); t++;
          if (valid && ready) begin idx++; wait_c = gap > 1 ? gap - 1 : 0; end
          else if (wait_c > 0) wait_c--;
          @(posedge clk); #1;
        end
        valid = 0;
        if (idx < len) tmo = 1;
      end
      begin
        int t = 0;
        while (done_cnt == 0 && t < 20000) begin
          if (t == hold) begin hold_acc = acc_cnt; hold_ready = ready; hold_wvalid = axi_wvalid; end
          axi_wready = t < hold ? 1'b0 : wmode == 1 ? (t % 2 == 1) : wmode == 2 ? ($urandom_range(0, 1) == 1) : 1'b1;
          @(posedge clk); #1; t++;
        end
        if (done_cnt == 0) tmo = 1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({done, ready, axi_wvalid, axi_wlast} !== 4'b0) begin
      failures++; $display("FAIL reset_outputs got=%b want=0000", {done, ready, axi_wvalid, axi_wlast});
    end
    clear_cap();
    valid = 1; data = 32'hdead_beef; axi_wready = 1;
    repeat (10) @(posedge clk);
    #1; valid = 0;
    checks++;
    if (acc_cnt !== 0 || cap_data.size() !== 0) begin
      failures++; $display("FAIL idle_ignore accepted=%0d beats=%0d want=0/0", acc_cnt, cap_data.size());
    end
  endtask

  task automatic test_stall_hold();
    seq_words(8);
    run_xfer(8, 0, 0, 30);
    checks++;
    if (hold_acc !== 8 || hold_ready !== 0 || hold_wvalid !== 1) begin
      failures++; $display("FAIL stall_hold acc=%0d ready=%b wvalid=%b want=8/0/1", hold_acc, hold_ready, hold_wvalid);
    end
    checks++;
    if (cap_data.size() !== 1 || cap_data[0] !== 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001 || cap_last[0] !== 1) begin
      failures++; $display("FAIL stall_beat beats=%0d", cap_data.size());
    end
    checks++;
    if (done_cnt !== 1 || stab_err !== 0 || tmo !== 0) begin
      failures++; $display("FAIL stall_done done=%0d stab=%0d tmo=%0d want=1/0/0", done_cnt, stab_err, tmo);
    end
  endtask

  task automatic test_slow_source();
    seq_words(8);
    run_xfer(8, 6, 0, 0);
    checks++;
    if (cap_data.size() !== exp_data.size()) begin
      failures++; $display("FAIL slow_count got=%0d want=%0d", cap_data.size(), exp_data.size());
    end
    foreach (exp_data[i]) if (i < cap_data.size()) begin
      checks++;
      if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
        failures++; $display("FAIL slow_beat%0d got=%h want=%h", i, {cap_last[i], cap_data[i]}, {exp_last[i], exp_data[i]});
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_pop_cyc + 1 || tmo !== 0) begin
      failures++; $display("FAIL slow_done cnt=%0d at=%0d want=1 at %0d", done_cnt, done_cyc, last_pop_cyc + 1);
    end
  endtask

  task automatic test_long();
    seq_words(4092);
    run_xfer(4092, 0, 0, 0);
    checks++;
    if (cap_data.size() !== 512) begin
      failures++; $display("FAIL long_count got=%0d want=512", cap_data.size());
    end
    foreach (exp_data[i]) if (i < cap_data.size()) begin
      checks++;
      if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
        failures++; $display("FAIL long_beat%0d got=%h want=%h", i, {cap_last[i], cap_data[i]}, {exp_last[i], exp_data[i]});
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_pop_cyc + 1 || stab_err !== 0 || tmo !== 0) begin
      failures++; $display("FAIL long_done cnt=%0d stab=%0d tmo=%0d want=1/0/0", done_cnt, stab_err, tmo);
    end
  endtask

  task automatic test_toggle_random();
    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(1, 300);
      rand_words(len);
      run_xfer(len, r < 3 ? 0 : -1, r < 3 ? 1 : 2, 0);
      checks++;
      if (cap_data.size() !== exp_data.size()) begin
        failures++; $display("FAIL rnd%0d_count len=%0d got=%0d want=%0d", r, len, cap_data.size(), exp_data.size());
      end
      foreach (exp_data[i]) if (i < cap_data.size()) begin
        checks++;
        if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
          failures++; $display("FAIL rnd%0d_beat%0d got=%h want=%h", r, i, {cap_last[i], cap_data[i]}, {exp_last[i], exp_data[i]});
        end
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== last_pop_cyc + 1 || stab_err !== 0 || tmo !== 0) begin
        failures++; $display("FAIL rnd%0d_done cnt=%0d stab=%0d tmo=%0d want=1/0/0", r, done_cnt, stab_err, tmo);
      end
    end
  endtask

  task automatic test_full();
    rand_words(200);
    run_xfer(200, 0, 0, 300);
    checks++;
    if (hold_acc !== 128 || hold_ready !== 0) begin
      failures++; $display("FAIL full_backpressure acc=%0d ready=%b want=128/0", hold_acc, hold_ready);
    end
    checks++;
    if (cap_data.size() !== 25) begin
      failures++; $display("FAIL full_count got=%0d want=25", cap_data.size());
    end
    foreach (exp_data[i]) if (i < cap_data.size()) begin
      checks++;
      if ({cap_last[i], cap_data[i]} !== {exp_last[i], exp_data[i]}) begin
        failures++; $display("FAIL full_beat%0d got=%h want=%h", i, {cap_last[i], cap_data[i]}, {exp_last[i], exp_data[i]});
      end
    end
    checks++;
    if (done_cnt !== 1 || stab_err !== 0 || tmo !== 0) begin
      failures++; $display("FAIL full_done cnt=%0d stab=%0d tmo=%0d want=1/0/0", done_cnt, stab_err, tmo);
    end
  endtask

  task automatic test_mid_reset();
    clear_cap();
    @(posedge clk); #1; cfg_length = 64; cfg_valid = 1; axi_wready = 0;
    @(posedge clk); #1; cfg_valid = 0; valid = 1;
    repeat (20) begin data = $urandom; @(posedge clk); #1; end
    rst = 1; valid = 0;
    @(posedge clk); #1; rst = 0;
    for (int k = 0; k < WR; k++) model_pack[k] = '0;
    checks++;
    if ({done, ready, axi_wvalid, axi_wlast} !== 4'b0) begin
      failures++; $display("FAIL midrst_outputs got=%b want=0000", {done, ready, axi_wvalid, axi_wlast});
    end
    axi_wready = 1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cap_data.size() !== 0 || done_cnt !== 0) begin
      failures++; $display("FAIL midrst_stale beats=%0d done=%0d want=0/0", cap_data.size(), done_cnt);
    end
    seq_words(8);
    run_xfer(8, 0, 2, 0);
    checks++;
    if (cap_data.size() !== 1 || {cap_last[0], cap_data[0]} !== {exp_last[0], exp_data[0]} || done_cnt !== 1) begin
      failures++; $display("FAIL midrst_after beats=%0d done=%0d want=1/1", cap_data.size(), done_cnt);
    end
  endtask

  task automatic test_zero_len();
    words.delete();
    run_xfer(0, 0, 0, 0);
    checks++;
    if (cap_data.size() !== 0 || done_cnt !== 1 || tmo !== 0) begin
      failures++; $display("FAIL zero_len beats=%0d done=%0d tmo=%0d want=0/1/0", cap_data.size(), done_cnt, tmo);
    end
  endtask

  initial begin
    rst = 1; cfg_valid = 0; cfg_length = 0; valid = 0; data = 0; axi_wready = 0;
    for (int k = 0; k < WR; k++) model_pack[k] = '0;
    repeat (3) @(posedge clk);
    #1; rst = 0;
    test_reset();
    test_stall_hold();
    test_slow_source();
    test_long();
    test_toggle_random();
    test_full();
    test_zero_len();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_write_data.md
AXIS_WRITE_DATA -- requirements
Module: axis_write_data

Interface
REQ-001 SHALL have parameter BUF_AWIDTH, default 4: log2 depth of the wide-beat output FIFO (16 entries).
REQ-002 SHALL have parameter CONFIG_DWIDTH, default 32: width of cfg_length.
REQ-003 SHALL have parameter WIDTH_RATIO, default 8: number of narrow words per AXI beat.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 256: AXI write-data width; must equal WIDTH_RATIO*DATA_WIDTH.
REQ-005 SHALL have parameter DATA_WIDTH, default 32: input stream word width.
REQ-006 SHALL have parameter BURST_LENGTH, default 256: beats per AXI burst, used for wlast.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port done, output, 1 bit: transfer-complete pulse.
REQ-010 SHALL have ports cfg_length, input, CONFIG_DWIDTH, and cfg_valid, input, 1: transfer length in narrow words, and its strobe.
REQ-011 SHALL have ports axi_wdata, output, AXI_DATA_WIDTH; axi_wvalid, output, 1; axi_wready, input, 1; axi_wlast, output, 1: the AXI W channel.
REQ-012 SHALL have ports data, input, DATA_WIDTH; valid, input, 1; ready, output, 1: the narrow input stream.

Function
REQ-013 SHALL implement state machine IDLE -> ACTIVE -> DONE -> IDLE, held in register "state".
REQ-014 In IDLE, cfg_valid=1 SHALL latch remaining-words = cfg_length and total beats = ceil(cfg_length/WIDTH_RATIO), then enter ACTIVE next cycle; cfg_valid outside IDLE SHALL be ignored; cfg_length=0 SHALL go straight to DONE.
REQ-015 ready SHALL be 1 only in ACTIVE while remaining-words>0 and the packer can accept a word (FIFO not full or the current beat incomplete).
REQ-016 A word SHALL be accepted when valid&&ready; each acceptance decrements remaining-words by one.
REQ-017 Packing SHALL be little-endian: the k-th word of a beat (k=0..WIDTH_RATIO-1) occupies axi_wdata[k*DATA_WIDTH +: DATA_WIDTH].
REQ-018 A beat SHALL be pushed to the FIFO the cycle after its WIDTH_RATIO-th word is accepted, or after the final word of the transfer (partial beat).
REQ-019 axi_wvalid SHALL equal FIFO not-empty; axi_wdata SHALL be the FIFO head; a beat pops on axi_wvalid&&axi_wready.
REQ-020 axi_wvalid/axi_wdata/axi_wlast SHALL remain stable while axi_wvalid=1 and axi_wready=0.
REQ-021 axi_wlast SHALL be 1 on beat indices BURST_LENGTH-1, 2*BURST_LENGTH-1, ... of the transfer, and on the final beat.
REQ-022 Simultaneous FIFO push and pop SHALL both occur; push SHALL never occur when full (ready back-pressures instead).
REQ-023 Transition ACTIVE -> DONE SHALL occur the cycle after the final beat pops; done SHALL be 1 for exactly one cycle in DONE, then IDLE.
REQ-024 Stream words arriving while ready=0 SHALL be ignored.

Reset
REQ-025 rst=1 SHALL, at the next clock edge, set state=IDLE, empty the FIFO, clear the packer and counters, and drive done=0, ready=0, axi_wvalid=0, axi_wlast=0.
REQ-026 rst asserted mid-transfer SHALL discard all buffered and partially packed data; no beat SHALL be emitted afterwards until a new cfg_valid.

Configuration
REQ-027 Macro AXIS_WRITE_DATA_ZERO_PAD_EN defined: unused lanes of a partial final beat SHALL be driven 0.
REQ-028 Macro undefined: unused lanes of a partial final beat SHALL hold the packer's previous contents (data from the prior beat, or 0 after reset).

Verification
REQ-029 Reset, cfg_length=8, axi_wready=1, words 1..5 sent, then wready=0, words 6..8 -> ready drops after 8 words; one beat 0x00000008_00000007_..._00000001 held with wvalid=1 until wready=1, then wlast=1, done pulses once.
REQ-030 cfg_length=8, words 1..8 sent one every 6 cycles, wready=1 -> single beat with words in lanes 0..7, wlast=1, done one cycle after the pop.
REQ-031 cfg_length=4092, words 1..4092 back-to-back, wready=1 -> 512 beats; wlast on beats 255 and 511; beat 511 lanes 4..7 = 0 with ZERO_PAD_EN; done once.
REQ-032 wready toggling 1/0 per cycle during drain -> no beat lost or duplicated; data stable while stalled.
REQ-033 cfg_length=200, wready=0 -> ready drops after 128 words (16-entry FIFO full); resumes when wready=1.
REQ-034 rst asserted mid-transfer, then cfg_length=8 -> no stale beats; new transfer completes normally.
